// File: rtl/periph_uart_tx_sched.sv
// ============================================================================
// periph_uart_tx_sched : byte FIFO drained into the UART data register in
// cycles the CPU leaves the peripheral port free.          Rev 1.0
// ============================================================================
`default_nettype none

module periph_uart_tx_sched #(
   parameter int         DEPTH     = 16,
   parameter logic [5:0] STAT_ADDR = 6'h09,
   parameter logic [5:0] DATA_ADDR = 6'h08,
   parameter int         IDLE_BIT  = 6,
   parameter int         POLL_GAP  = 8
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     cpu_cs,
   input  logic                     cpu_oe,
   input  logic [3:0]               cpu_wstrb,
   input  logic [5:0]               cpu_addr,
   input  logic [31:0]              cpu_wdata,
   output logic [31:0]              cpu_rdata,
   input  logic                     tx_valid,
   input  logic [7:0]               tx_data,
   output logic                     tx_ready,
   output logic                     p_cs,
   output logic                     p_oe,
   output logic [3:0]               p_wstrb,
   output logic [5:0]               p_addr,
   output logic [31:0]              p_wdata,
   input  logic [31:0]              p_rdata,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_POLL  = 2'd1,
      ST_WAIT  = 2'd2,
      ST_WRITE = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    gap_q, gap_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [7:0]    mem_q [DEPTH];

   logic          push;
   logic          pop;
   logic          grant;
   logic          eng_cs;
   logic          eng_oe;
   logic [3:0]    eng_wstrb;
   logic [5:0]    eng_addr;
   logic [31:0]   eng_wdata;

   assign grant      = ~cpu_cs;
   assign tx_ready   = (level_q != LW'(DEPTH));
   assign push       = tx_valid & tx_ready;
   assign fifo_level = level_q;
   assign busy       = (level_q != '0) || (state_q != ST_IDLE);
   assign cpu_rdata  = p_rdata;

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q + LW'(push) - LW'(pop);
   end

   always_comb begin
      state_d   = state_q;
      gap_d     = gap_q;
      pop       = 1'b0;
      eng_cs    = 1'b0;
      eng_oe    = 1'b0;
      eng_wstrb = 4'b0000;
      eng_addr  = 6'h00;
      eng_wdata = 32'h0;
      case (state_q)
         ST_IDLE: begin
            if (level_q != '0) state_d = ST_POLL;
         end
         ST_POLL: begin
            eng_cs   = 1'b1;
            eng_oe   = 1'b1;
            eng_addr = STAT_ADDR;
            if (grant) begin
               if (p_rdata[IDLE_BIT]) begin
                  state_d = ST_WRITE;
               end else if (POLL_GAP != 0) begin
                  gap_d   = 8'(POLL_GAP);
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            gap_d = gap_q - 8'd1;
            if (gap_q <= 8'd1) state_d = ST_POLL;
         end
         ST_WRITE: begin
            eng_cs    = 1'b1;
            eng_wstrb = 4'b0001;
            eng_addr  = DATA_ADDR;
            eng_wdata = {24'h0, mem_q[rd_ptr_q]};
            if (grant) begin
               pop = 1'b1;
               // Level after this pop, counting a push landing on the same edge
               state_d = ((level_q > LW'(1)) || push) ? ST_POLL : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      if (cpu_cs) begin
         p_cs    = 1'b1;
         p_oe    = cpu_oe;
         p_wstrb = cpu_wstrb;
         p_addr  = cpu_addr;
         p_wdata = cpu_wdata;
      end else begin
         p_cs    = eng_cs;
         p_oe    = eng_oe;
         p_wstrb = eng_wstrb;
         p_addr  = eng_addr;
         p_wdata = eng_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q  <= ST_IDLE;
         gap_q    <= 8'd0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         state_q  <= state_d;
         gap_q    <= gap_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and level
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= tx_data;
   end

endmodule

`default_nettype wire

// File: tb/tb_periph_uart_tx_sched.sv
// ============================================================================
// tb_periph_uart_tx_sched : scoreboard bench for periph_uart_tx_sched. Rev 1.0
// ============================================================================
`default_nettype none

module tb_periph_uart_tx_sched;

   localparam logic [5:0] STAT = 6'h09;
   localparam logic [5:0] DATA = 6'h08;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        cpu_cs = 1'b0;
   logic        cpu_oe = 1'b0;
   logic [3:0]  cpu_wstrb = 4'h0;
   logic [5:0]  cpu_addr = 6'h00;
   logic [31:0] cpu_wdata = 32'h0;
   logic [31:0] cpu_rdata;
   logic        tx_valid = 1'b0;
   logic [7:0]  tx_data = 8'h00;
   logic        tx_ready;
   logic        p_cs;
   logic        p_oe;
   logic [3:0]  p_wstrb;
   logic [5:0]  p_addr;
   logic [31:0] p_wdata;
   logic [31:0] p_rdata;
   logic [4:0]  fifo_level;
   logic        busy;

   periph_uart_tx_sched dut (
      .clk        (clk),
      .nrst       (nrst),
      .cpu_cs     (cpu_cs),
      .cpu_oe     (cpu_oe),
      .cpu_wstrb  (cpu_wstrb),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .p_cs       (p_cs),
      .p_oe       (p_oe),
      .p_wstrb    (p_wstrb),
      .p_addr     (p_addr),
      .p_wdata    (p_wdata),
      .p_rdata    (p_rdata),
      .fifo_level (fifo_level),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Peripheral model: status reads busy until 'busy_until' polls have been seen
   int polls = 0;
   int busy_until = 0;
   int cyc = 0;
   int wr_cnt = 0;
   int poll_cyc [1024];
   logic [7:0] sb [$];

   assign p_rdata = (p_cs && p_oe && p_addr == STAT) ?
                    ((polls < busy_until) ? 32'h0000_0000 : 32'h0000_0060) :
                    (32'hA5A5_0000 | {26'h0, p_addr});

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (nrst && !cpu_cs && p_cs && p_oe && p_addr == STAT) begin
         poll_cyc[polls % 1024] <= cyc;
         polls <= polls + 1;
      end
   end

   always @(negedge clk) begin
      if (nrst && !cpu_cs && p_cs && p_wstrb == 4'b0001 && p_addr == DATA) begin
         wr_cnt++;
         if (sb.size() == 0) check("wr_unexpected", 32'(sb.size()), 32'd1);
         else check("wr_byte", p_wdata, {24'h0, sb.pop_front()});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d, output logic acc);
      tx_valid = 1'b1;
      tx_data  = d;
      acc      = tx_ready;
      if (acc) sb.push_back(d);
      tick();
      tx_valid = 1'b0;
   endtask

   task automatic drain(input string tag, input int max);
      int n = 0;
      while ((busy || sb.size() != 0) && n < max) begin
         tick();
         n++;
      end
      check({tag, "_drain"}, 32'(busy || sb.size() != 0), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic acc;
      int   base;
      int   w0;
      int   n;

      // Reset state and pass-through during reset
      nrst = 1'b0;
      tick();
      tick();
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_ready", 32'(tx_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pcs", 32'(p_cs), 32'd0);
      cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_addr = 6'h0a;
      cpu_wdata = 32'hDEAD_BEEF; cpu_wstrb = 4'hF;
      #1;
      check("rst_pass_addr", 32'(p_addr), 32'h0a);
      check("rst_pass_wstrb", 32'(p_wstrb), 32'hF);
      check("rst_pass_wdata", p_wdata, 32'hDEAD_BEEF);
      check("rst_pass_rdata", cpu_rdata, 32'hA5A5_000A);
      cpu_cs = 1'b0; cpu_oe = 1'b0; cpu_addr = 6'h00;
      cpu_wdata = 32'h0; cpu_wstrb = 4'h0;
      nrst = 1'b1;
      tick();

      // Minimum latency: IDLE, POLL, WRITE
      busy_until = polls;
      push(8'h41, acc);
      check("t1_level1", 32'(fifo_level), 32'd1);
      check("t1_idle_pcs", 32'(p_cs), 32'd0);
      tick();
      check("t1_poll_cs", 32'(p_cs), 32'd1);
      check("t1_poll_oe", 32'(p_oe), 32'd1);
      check("t1_poll_addr", 32'(p_addr), 32'h09);
      tick();
      check("t1_wr_strb", 32'(p_wstrb), 32'h1);
      check("t1_wr_addr", 32'(p_addr), 32'h08);
      check("t1_wr_data", p_wdata, 32'h41);
      tick();
      check("t1_level0", 32'(fifo_level), 32'd0);
      check("t1_busy0", 32'(busy), 32'd0);

      // Poll spacing while transmitter busy
      base = polls;
      w0 = wr_cnt;
      busy_until = polls + 3;
      push(8'h55, acc);
      drain("t2", 200);
      check("t2_polls", 32'(polls - base), 32'd4);
      for (int i = 1; i < 4; i++)
         check("t2_gap", 32'(poll_cyc[(base + i) % 1024] - poll_cyc[(base + i - 1) % 1024]), 32'd9);
      check("t2_writes", 32'(wr_cnt - w0), 32'd1);

      // CPU holds the port while the engine sits in POLL
      busy_until = polls;
      push(8'h77, acc);
      tick();
      base = polls;
      cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_addr = 6'h0a;
      cpu_wstrb = 4'h0; cpu_wdata = 32'h1234_5678;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("t3_cs", 32'(p_cs), 32'd1);
         check("t3_addr", 32'(p_addr), 32'h0a);
         check("t3_wdata", p_wdata, 32'h1234_5678);
         check("t3_rdata", cpu_rdata, 32'hA5A5_000A);
         @(posedge clk);
         #1;
      end
      cpu_cs = 1'b0; cpu_oe = 1'b0; cpu_addr = 6'h00; cpu_wdata = 32'h0;
      #1;
      check("t3_poll_addr", 32'(p_addr), 32'h09);
      check("t3_poll_oe", 32'(p_oe), 32'd1);
      check("t3_no_poll_during_cpu", 32'(polls - base), 32'd0);
      tick();
      check("t3_poll_after", 32'(polls - base), 32'd1);
      drain("t3", 50);

      // Fill to full with the UART busy, then release
      busy_until = polls + 1000;
      for (int i = 1; i <= 16; i++) push(8'(i), acc);
      check("t4_ready_full", 32'(tx_ready), 32'd0);
      check("t4_level_full", 32'(fifo_level), 32'd16);
      push(8'd17, acc);
      check("t4_push17_refused", 32'(acc), 32'd0);
      check("t4_level_still", 32'(fifo_level), 32'd16);
      busy_until = polls;
      drain("t4", 400);

      // Reset while waiting between polls with five bytes queued
      busy_until = polls + 1000;
      for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i), acc);
      base = polls;
      n = 0;
      while (polls == base && n < 50) begin
         tick();
         n++;
      end
      check("t5_poll_seen", 32'(polls != base), 32'd1);
      tick();
      check("t5_level5", 32'(fifo_level), 32'd5);
      check("t5_wait_pcs", 32'(p_cs), 32'd0);
      nrst = 1'b0;
      tick();
      nrst = 1'b1;
      sb.delete();
      check("t5_level0", 32'(fifo_level), 32'd0);
      check("t5_busy0", 32'(busy), 32'd0);
      check("t5_pcs0", 32'(p_cs), 32'd0);
      tick();
      check("t5_pcs0_next", 32'(p_cs), 32'd0);

      // Simultaneous push and pop at level 3
      busy_until = polls + 1000;
      for (int i = 0; i < 3; i++) push(8'hA1 + 8'(i), acc);
      check("t6_level3", 32'(fifo_level), 32'd3);
      busy_until = polls;
      n = 0;
      while (!(p_cs && !cpu_cs && p_wstrb == 4'b0001) && n < 60) begin
         tick();
         n++;
      end
      check("t6_in_write", 32'(p_wstrb), 32'h1);
      check("t6_level_pre", 32'(fifo_level), 32'd3);
      push(8'hA4, acc);
      check("t6_push_acc", 32'(acc), 32'd1);
      check("t6_level_post", 32'(fifo_level), 32'd3);
      drain("t6", 100);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
